// File: rtl/bitstuff_inserter_if.sv
// bitstuff_inserter_if: valid/ready NRZ bit-stream bundle around the stuffing engine.
interface bitstuff_inserter_if #(parameter int STAT_W = 8);
  logic pkt_start, stuff_en, in_bit, in_valid, in_last, in_ready;
  logic out_bit, out_valid, out_ready, stuffing;
  logic [STAT_W-1:0] stuff_cnt;
  modport master (
    output pkt_start, stuff_en, in_bit, in_valid, in_last, out_ready,
    input  in_ready, out_bit, out_valid, stuffing, stuff_cnt
  );
  modport slave (
    input  pkt_start, stuff_en, in_bit, in_valid, in_last, out_ready,
    output in_ready, out_bit, out_valid, stuffing, stuff_cnt
  );
endinterface

// File: rtl/bitstuff_inserter.sv
// bitstuff_inserter: inserts a zero after RUN_LEN consecutive ones and counts stuffed bits per packet.
module bitstuff_inserter #(
  parameter int RUN_LEN = 6,
  parameter int STAT_W  = 8
) (
  input logic clk,
  input logic reset_n,
  bitstuff_inserter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACTIVE, STUFF} state_t;
  state_t state;
  logic mode, end_pend, stf, xfer, hit;
  logic [3:0] run, run_inc;
  logic [STAT_W-1:0] cnt;
  assign stf           = state == STUFF;
  assign xfer          = bus.in_valid & bus.in_ready;
  assign run_inc       = run + 4'd1;
  assign hit           = run_inc == 4'(RUN_LEN);
  assign bus.stuffing  = stf;
  assign bus.out_bit   = bus.in_bit & ~stf;
  assign bus.out_valid = bus.in_valid | stf;
  assign bus.in_ready  = bus.out_ready & ~stf;
  assign bus.stuff_cnt = cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      run      <= '0;
      mode     <= 1'b0;
      end_pend <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (bus.pkt_start) begin
          state <= ACTIVE;
          mode  <= bus.stuff_en;
          run   <= '0;
          cnt   <= '0;
        end
        ACTIVE: if (xfer) begin
          if (mode && bus.in_bit && hit) begin
            run      <= '0;
            state    <= STUFF;
            end_pend <= bus.in_last;
          end else begin
            if (mode) run <= bus.in_bit ? run_inc : 4'd0;
            if (bus.in_last) state <= IDLE;
          end
        end
        STUFF: if (bus.out_ready) begin
          if (!(&cnt)) cnt <= cnt + STAT_W'(1);
          state <= end_pend ? IDLE : ACTIVE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bitstuff_inserter.sv
// tb_bitstuff_inserter: stream-level scoreboard over three parameterisations of the stuffing engine.
module tb_bitstuff_inserter;
  logic clk = 0, reset_n = 0;
  always #5 clk = ~clk;
  logic [2:0] pkt_start = '0, stuff_en = '0, in_bit = '0, in_valid = '0, in_last = '0, out_ready = '1;
  logic [2:0] in_ready, out_bit, out_valid, stuffing;
  logic [7:0] cnt [3];
  bitstuff_inserter_if #(.STAT_W(8)) b0 ();
  bitstuff_inserter_if #(.STAT_W(2)) b1 ();
  bitstuff_inserter_if #(.STAT_W(8)) b2 ();
  bitstuff_inserter #(.RUN_LEN(6), .STAT_W(8)) u0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  bitstuff_inserter #(.RUN_LEN(6), .STAT_W(2)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1));
  bitstuff_inserter #(.RUN_LEN(1), .STAT_W(8)) u2 (.clk(clk), .reset_n(reset_n), .bus(b2));
  assign b0.pkt_start = pkt_start[0]; assign b0.stuff_en = stuff_en[0]; assign b0.in_bit = in_bit[0];
  assign b0.in_valid = in_valid[0]; assign b0.in_last = in_last[0]; assign b0.out_ready = out_ready[0];
  assign b1.pkt_start = pkt_start[1]; assign b1.stuff_en = stuff_en[1]; assign b1.in_bit = in_bit[1];
  assign b1.in_valid = in_valid[1]; assign b1.in_last = in_last[1]; assign b1.out_ready = out_ready[1];
  assign b2.pkt_start = pkt_start[2]; assign b2.stuff_en = stuff_en[2]; assign b2.in_bit = in_bit[2];
  assign b2.in_valid = in_valid[2]; assign b2.in_last = in_last[2]; assign b2.out_ready = out_ready[2];
  assign in_ready  = {b2.in_ready, b1.in_ready, b0.in_ready};
  assign out_bit   = {b2.out_bit, b1.out_bit, b0.out_bit};
  assign out_valid = {b2.out_valid, b1.out_valid, b0.out_valid};
  assign stuffing  = {b2.stuffing, b1.stuffing, b0.stuffing};
  assign cnt[0] = b0.stuff_cnt;
  assign cnt[1] = {6'd0, b1.stuff_cnt};
  assign cnt[2] = b2.stuff_cnt;

  int n_cmp = 0, n_bad = 0;
  int d = 0;
  bit rnd = 0;
  // Reference: expected output stream as {is_stuffed, bit}, built from accepted input bits.
  logic [1:0] q[$];
  bit m_act = 0, m_mode = 0;
  int ones = 0, m_stf = 0, stf_cycles = 0;

  function automatic int rl_of(int i);
    return i == 2 ? 1 : 6;
  endfunction
  function automatic int cmax(int i);
    return i == 1 ? 3 : 255;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_act = 0; m_mode = 0; ones = 0; m_stf = 0;
  endtask

  always @(negedge clk) if (reset_n) begin
    logic [1:0] e;
    if (stuffing[d]) begin
      stf_cycles++;
      check("stuff_in_ready", in_ready[d], 0);
      check("stuff_out_valid", out_valid[d], 1);
      check("stuff_out_bit", out_bit[d], 0);
    end else begin
      check("pass_valid", out_valid[d], in_valid[d]);
      check("pass_ready", in_ready[d], out_ready[d]);
    end
    if (in_valid[d] && in_ready[d]) begin
      q.push_back({1'b0, in_bit[d]});
      if (m_act && m_mode) begin
        ones = in_bit[d] ? ones + 1 : 0;
        if (ones == rl_of(d)) begin
          q.push_back(2'b10);
          ones = 0;
          if (m_stf < cmax(d)) m_stf++;
        end
      end
      if (m_act && in_last[d]) m_act = 0;
    end
    if (out_valid[d] && out_ready[d]) begin
      e = q.size() != 0 ? q.pop_front() : 2'bxx;
      check("out_stream", {stuffing[d], out_bit[d]}, e);
    end
    if (pkt_start[d] && !m_act) begin
      m_act = 1; m_mode = stuff_en[d]; ones = 0; m_stf = 0;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic start_pkt(input logic en);
    out_ready[d] = 1;
    pkt_start[d] = 1; stuff_en[d] = en;
    in_valid[d] = 1'($urandom_range(0, 1)); in_bit[d] = 1'($urandom_range(0, 1));
    in_last[d] = 1'($urandom_range(0, 1));
    cyc();
    pkt_start[d] = 0; stuff_en[d] = 0; in_valid[d] = 0; in_last[d] = 0;
    check("cnt_cleared", cnt[d], 0);
  endtask

  task automatic send_bit(input logic b, input logic last);
    logic done;
    done = 0;
    in_valid[d] = 1; in_bit[d] = b; in_last[d] = last;
    for (int k = 0; k < 100 && !done; k++) begin
      if (rnd) out_ready[d] = $urandom_range(0, 2) != 0;
      @(negedge clk); done = in_ready[d];
      cyc();
    end
    if (!done) check("send_timeout", done, 1);
    in_valid[d] = 0; in_last[d] = 0;
  endtask

  task automatic send_ones(input int n, input logic last_on_final);
    for (int i = 0; i < n; i++) send_bit(1, last_on_final && i == n - 1);
  endtask

  task automatic drain();
    in_valid[d] = 0; out_ready[d] = 1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #2;
      if (q.size() == 0 && !stuffing[d]) break;
    end
    check("drain_queue", q.size(), 0);
    cyc();
  endtask

  initial begin
    in_valid[0] = 1;
    #3;
    check("rst_stuffing", stuffing[0], 0);
    check("rst_cnt", cnt[0], 0);
    check("rst_out_valid", out_valid[0], 1);
    check("rst_in_ready", in_ready[0], 1);
    in_valid[0] = 0;
    #20 reset_n = 1;
    cyc();
    // Basic: 1111111 0 -> 111111 0 1 0
    d = 0; rnd = 0; stf_cycles = 0;
    start_pkt(1);
    send_ones(7, 0); send_bit(0, 1);
    drain();
    check("basic_cnt", cnt[0], 1);
    check("basic_stuff_cycles", stf_cycles, 1);
    // Run reset: 11111 0 111111 -> single stuff at the end
    start_pkt(1);
    send_ones(5, 0); send_bit(0, 0); send_ones(6, 1);
    drain();
    check("runreset_cnt", cnt[0], 1);
    // End-of-packet stuff, then pkt_start clears the count
    start_pkt(1);
    send_ones(6, 1);
    drain();
    check("eop_cnt", cnt[0], 1);
    start_pkt(1);
    send_bit(0, 1);
    drain();
    // Bypass
    start_pkt(0);
    send_ones(20, 1);
    drain();
    check("bypass_cnt", cnt[0], 0);
    // Backpressure on the stuffed zero
    start_pkt(1);
    send_ones(6, 0);
    out_ready[0] = 0;
    for (int i = 0; i < 3; i++) begin
      check("bp_stuffing", stuffing[0], 1);
      check("bp_out_bit", out_bit[0], 0);
      check("bp_out_valid", out_valid[0], 1);
      cyc();
    end
    out_ready[0] = 1;
    check("bp_still_stuffing", stuffing[0], 1);
    cyc();
    check("bp_left_stuff", stuffing[0], 0);
    send_bit(1, 1);
    drain();
    check("bp_cnt", cnt[0], 1);
    // Asynchronous reset while stuffing
    start_pkt(1);
    send_ones(6, 0);
    out_ready[0] = 0; in_valid[0] = 1; in_bit[0] = 1;
    check("pre_rst_stuffing", stuffing[0], 1);
    #1 reset_n = 0;
    #1;
    check("async_rst_stuffing", stuffing[0], 0);
    check("async_rst_out_valid", out_valid[0], in_valid[0]);
    check("async_rst_cnt", cnt[0], 0);
    model_clear();
    in_valid[0] = 0; out_ready[0] = 1;
    @(negedge clk); #1 reset_n = 1;
    cyc();
    send_ones(10, 0);
    drain();
    check("post_rst_cnt", cnt[0], 0);
    // Saturation with a 2-bit counter
    d = 1;
    start_pkt(1);
    send_ones(30, 0); send_bit(0, 1);
    drain();
    check("sat_cnt", cnt[1], 3);
    // RUN_LEN=1: 1 1 -> 1 0 1 0
    d = 2;
    start_pkt(1);
    send_ones(2, 1);
    drain();
    check("rl1_cnt", cnt[2], 2);
    // Randomised packets on every parameterisation
    rnd = 1;
    for (int dd = 0; dd < 3; dd++) begin
      d = dd;
      for (int p = 0; p < 20; p++) begin
        int n;
        start_pkt($urandom_range(0, 4) != 0);
        n = $urandom_range(1, 40);
        for (int i = 0; i < n; i++) send_bit($urandom_range(0, 5) != 0, i == n - 1);
        drain();
        check("rand_cnt", cnt[d], m_stf);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
